// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Pipelined ALU with a registered result stage. Single-cycle ops (0x0..0xD)
//   complete on the accept edge. With ALU_PIPE_MUL_EN defined, MUL/MULH
//   (0xE/0xF) run through a radix-2 shift-add multiplier. Without the macro,
//   0xE/0xF finish in one cycle with result 0, flags held and err=1.
//
// Configuration macro: ALU_PIPE_MUL_EN (enables multiplier and MUL state)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid          in_ready   request accepted this cycle
//   op[3:0]    opcode                 a, b       operands (WIDTH bits)
//   out_valid  result valid           out_ready  consumer takes result
//   result     registered result      flags      registered {C,V,Z,N}
//   err        registered illegal-opcode indication
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready low, result/flags/err hold stable.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic             c_flag;
  logic             accept;

  // What gets written into the output stage on a completing op.
  logic             load;
  logic [WIDTH-1:0] load_res;
  logic [3:0]       load_flags;
  logic             load_err;

  // The carry register is the C bit of the flags register.
  assign c_flag = flags_q[3];
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Shared adder for ADD/ADC/SUB/SBB. op[1] selects subtract (invert b);
  // op[0] selects carry-in from C, otherwise carry-in is 1 for SUB, 0 for ADD.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_b   = op[1] ? ~b : b;
    add_cin = op[0] ? c_flag : op[1];
    add_sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. The default branch covers 0xE/0xF as the illegal-op
  // response; when the multiplier is built those opcodes never take this path.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [3:0]       alu_flags;

  always_comb begin
    alu_res = '0;
    alu_c   = c_flag;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        // Same-sign operands producing an opposite-sign sum.
        alu_v   = (a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h4: alu_res = a & b;
      4'h5: alu_res = a | b;
      4'h6: alu_res = a ^ b;
      4'h7: alu_res = a & ~b;
      4'h8: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      4'h9: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'hA: begin
        alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'hB: begin
        alu_res = {a[WIDTH-2:0], c_flag};
        alu_c   = a[WIDTH-1];
      end
      4'hC: begin
        alu_res = {c_flag, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      4'hD: alu_res = b;
      default: alu_err = 1'b1;
    endcase
  end

  assign alu_flags = alu_err ? flags_q
                             : {alu_c, alu_v, (alu_res == '0), alu_res[WIDTH-1]};

`ifdef ALU_PIPE_MUL_EN
  // ---------------------------------------------------------------------------
  // Multiplier: IDLE/MUL FSM, one partial product per cycle for WIDTH cycles.
  // The last partial product is folded in combinationally on the final edge,
  // so the result registers WIDTH edges after the accept edge.
  // ---------------------------------------------------------------------------
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;
  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mulh_q, mulh_d;
  logic               mul_done;
  logic               is_mul_op;
  logic [WIDTH-1:0]   mul_lo, mul_hi, mul_res;

  assign is_mul_op = (op[3:1] == 3'b111);
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_lo    = acc_sum[WIDTH-1:0];
  assign mul_hi    = acc_sum[2*WIDTH-1:WIDTH];
  assign mul_res   = mulh_q ? mul_hi : mul_lo;
  assign mul_done  = (state_q == S_MUL) && (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mulh_d     = mulh_q;
    load       = 1'b0;
    load_res   = alu_res;
    load_flags = alu_flags;
    load_err   = alu_err;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op) begin
            // Operands captured here; later changes on a/b/op are ignored.
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            mulh_d   = op[0];
          end else begin
            load = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (mul_done) begin
          state_d    = S_IDLE;
          load       = 1'b1;
          load_res   = mul_res;
          load_flags = {(mul_hi != '0), 1'b0, (mul_res == '0), mul_res[WIDTH-1]};
          load_err   = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mulh_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mulh_q   <= mulh_d;
    end
  end
`else
  // No multiplier: every opcode completes on its accept edge.
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    load       = accept;
    load_res   = alu_res;
    load_flags = alu_flags;
    load_err   = alu_err;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output stage. A new result may load on the same edge the old one drains.
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    if (load) begin
      result_d    = load_res;
      flags_d     = load_flags;
      err_d       = load_err;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Self-checking bench for alu_pipe (WIDTH=8). A behavioural model computes
//   each op from plain arithmetic and queues the expected {err,flags,result};
//   every cycle in_ready/out_valid and the pending output are compared.
//   Works with or without ALU_PIPE_MUL_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op        = '0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [12:0] exp_q[$];        // {err, flags[3:0], result[7:0]}
  logic [3:0]  m_flags = '0;    // architectural flags, m_flags[3] is C
  int          m_mul_left = 0;  // cycles until a pending multiply completes
  logic [12:0] m_mul_pkt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on unsigned/signed values.
  function automatic logic [12:0] model_op(input logic [3:0] o, input logic [7:0] aa,
                                           input logic [7:0] bb, input logic [3:0] fl);
    longint ua, ub, ci, s, sa, sb, ss, p;
    logic   c, v;
    logic [7:0] r;
    ua = longint'(aa);
    ub = longint'(bb);
    c  = fl[3];
    v  = 1'b0;
    r  = '0;
    case (o)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        if (o >= 4'h2) ub = 255 - ub;
        ci = (o == 4'h0) ? 0 : (o == 4'h2) ? 1 : longint'(fl[3]);
        s  = ua + ub + ci;
        r  = 8'(s);
        c  = (s > 255);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        ss = sa + sb + ci;
        v  = (ss > 127) || (ss < -128);
      end
      4'h4: r = aa & bb;
      4'h5: r = aa | bb;
      4'h6: r = aa ^ bb;
      4'h7: r = aa & ~bb;
      4'h8: begin r = 8'(ua * 2);                           c = (ua >= 128);    end
      4'h9: begin r = 8'(ua / 2);                           c = (ua % 2) != 0;  end
      4'hA: begin r = 8'(ua / 2 + ((ua >= 128) ? 128 : 0)); c = (ua % 2) != 0;  end
      4'hB: begin r = 8'(ua * 2 + longint'(fl[3]));         c = (ua >= 128);    end
      4'hC: begin r = 8'(ua / 2 + (fl[3] ? 128 : 0));       c = (ua % 2) != 0;  end
      4'hD: r = bb;
      default: begin
`ifdef ALU_PIPE_MUL_EN
        p = ua * ub;
        r = (o == 4'hE) ? 8'(p) : 8'(p / 256);
        c = (p > 255);
`else
        return {1'b1, fl, 8'h00};
`endif
      end
    endcase
    return {1'b0, c, v, (r == 8'h00), r[7], r};
  endfunction

  // ---------------------------------------------------------------- driver
  // Called just after a falling edge: drive, compare, advance one clock.
  task automatic step(input logic iv, input logic [3:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, input logic ordy);
    logic exp_ir, acc, xfer;
    logic [12:0] pkt;
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    #1;
    exp_ir = (m_mul_left == 0) && ((exp_q.size() == 0) || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_pkt", 32'({err, flags, result}), 32'(exp_q[0]));
    acc  = iv && exp_ir;
    xfer = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (xfer) void'(exp_q.pop_front());
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        exp_q.push_back(m_mul_pkt);
        m_flags = m_mul_pkt[11:8];
      end
    end else if (acc) begin
      pkt = model_op(o, aa, bb, m_flags);
`ifdef ALU_PIPE_MUL_EN
      if (o >= 4'hE) begin
        m_mul_left = W;
        m_mul_pkt  = pkt;
      end else
`endif
      begin
        exp_q.push_back(pkt);
        m_flags = pkt[11:8];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    m_flags    = '0;
    m_mul_left = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------------------------------------------------------- main
  initial begin
    int lat, low;

    // Model pinned against hand-computed values.
    chk("model_add_ovf", 32'(model_op(4'h0, 8'h7F, 8'h01, 4'h0)), 32'h0580);
    chk("model_sbb",     32'(model_op(4'h3, 8'h10, 8'h20, 4'h8)), 32'h01F0);
    chk("model_rorc",    32'(model_op(4'hC, 8'h01, 8'h00, 4'h8)), 32'h0980);

    @(negedge clk);
    do_reset(2);

    // ADD overflow into sign bit.
    step(1'b1, 4'h0, 8'h7F, 8'h01, 1'b1);
    chk("add_7f_res", 32'(result), 32'h80);
    chk("add_7f_flags", 32'(flags), 32'b0101);
    chk("add_7f_valid", 32'(out_valid), 32'h1);

    // Carry wrap then ADC back-to-back, then SUB equal operands.
    step(1'b1, 4'h0, 8'hFF, 8'h01, 1'b1);
    chk("add_ff_res", 32'(result), 32'h00);
    chk("add_ff_flags", 32'(flags), 32'b1010);
    step(1'b1, 4'h1, 8'h00, 8'h00, 1'b1);
    chk("adc_res", 32'(result), 32'h01);
    chk("adc_flags", 32'(flags), 32'b0000);
    step(1'b1, 4'h2, 8'h10, 8'h10, 1'b1);
    chk("sub_res", 32'(result), 32'h00);
    chk("sub_flags", 32'(flags), 32'b1010);

`ifdef ALU_PIPE_MUL_EN
    // MUL latency and busy window, with junk requests during the multiply.
    step(1'b1, 4'hE, 8'h0F, 8'h11, 1'b1);
    lat = 1;
    low = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) low++;
      step(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'b1);
      lat++;
    end
    chk("mul_latency", 32'(lat), 32'd9);
    chk("mul_busy_cycles", 32'(low), 32'd8);
    chk("mul_res", 32'(result), 32'hFF);
    chk("mul_flags", 32'(flags), 32'b0001);
    step(1'b1, 4'hF, 8'h10, 8'h10, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      lat++;
    end
    chk("mulh_latency", 32'(lat), 32'd9);
    chk("mulh_res", 32'(result), 32'h01);
    chk("mulh_flags", 32'(flags), 32'b1000);
    chk("mulh_err", 32'(err), 32'h0);
`else
    // Illegal op without multiplier: result 0, flags from SUB kept, err set.
    step(1'b1, 4'hE, 8'h12, 8'h34, 1'b1);
    chk("ill_res", 32'(result), 32'h00);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_flags", 32'(flags), 32'b1010);
    chk("ill_latency_valid", 32'(out_valid), 32'h1);
`endif

    // Back-pressure: hold for 3 cycles, pending request taken on release.
    step(1'b1, 4'h0, 8'h05, 8'h06, 1'b1);
    repeat (3) begin
      step(1'b1, 4'h0, 8'hAA, 8'hBB, 1'b0);
      chk("stall_res", 32'(result), 32'h0B);
      chk("stall_flags", 32'(flags), 32'b0000);
    end
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    step(1'b1, 4'h0, 8'hAA, 8'hBB, 1'b1);
    chk("release_res", 32'(result), 32'h65);
    chk("release_flags", 32'(flags), 32'b1100);

    // Reset in flight, then a fresh ADD.
`ifdef ALU_PIPE_MUL_EN
    step(1'b1, 4'hE, 8'h0F, 8'h11, 1'b1);
    repeat (3) step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
`else
    step(1'b1, 4'h0, 8'h01, 8'h01, 1'b0);
`endif
    do_reset(2);
    step(1'b1, 4'h0, 8'h02, 8'h03, 1'b1);
    chk("post_rst_res", 32'(result), 32'h05);
    chk("post_rst_flags", 32'(flags), 32'b0000);
    repeat (12) step(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);

    // Randomised traffic with random back-pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick_operand(),
           pick_operand(), $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits, legal range 4..32.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: op  input  4  opcode, sampled on accept.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands, sampled on accept.
REQ-008 SHALL have port: out_valid  output  1  result/flags valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port: result  output  WIDTH  registered result.
REQ-011 SHALL have port: flags  output  4  registered {C,V,Z,N} (bit 3 = C).
REQ-012 SHALL have port: err  output  1  registered illegal-opcode indication.

Function
REQ-013 Opcodes SHALL be: 0 ADD a+b; 1 ADC a+b+C; 2 SUB a+~b+1; 3 SBB a+~b+C; 4 AND; 5 OR; 6 XOR; 7 ANDN a&~b; 8 SHL a<<1; 9 SHR a>>1; A ASR; B ROLC {a,C} rotate left; C RORC rotate right through C; D MOV b; E MUL low WIDTH bits of a*b; F MULH high WIDTH bits of a*b.
REQ-014 C SHALL be the internal carry register, updated on every completed op; ADC/SBB/ROLC/RORC SHALL use its value after all prior accepted ops complete.
REQ-015 Arithmetic flags: C = carry-out of bit WIDTH-1 (SUB/SBB: 1 = no borrow); V = signed overflow (carry into MSB XOR carry-out).
REQ-016 Logic ops and MOV: C unchanged, V=0. Shifts/rotates: C = bit shifted out, V=0. MUL/MULH: C = 1 iff high half nonzero, V=0.
REQ-017 Z = (result==0), N = result[WIDTH-1], for every op.
REQ-018 States SHALL be IDLE and MUL; accept (in_valid & in_ready) of ops 0-D stays IDLE; of E/F enters MUL.
REQ-019 in_ready SHALL be 1 iff state==IDLE and (out_valid==0 or out_ready==1).
REQ-020 Ops 0-D: result/flags/out_valid=1 registered on the accept edge; latency 1 cycle; back-to-back accepts every cycle SHALL be sustained when out_ready=1.
REQ-021 MUL: radix-2 shift-add, one partial product per cycle, WIDTH cycles in MUL; out_valid asserts WIDTH+1 cycles after accept; then returns to IDLE.
REQ-022 out_valid=1 with out_ready=0 SHALL hold result, flags, err stable; out_valid clears on out_ready unless a new result loads the same edge.
REQ-023 in_valid while in_ready=0 SHALL be ignored; op/a/b changes during MUL SHALL not affect the result.
REQ-024 Carry wrap-around: all sums truncated to WIDTH bits, carry-out only to C.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, out_valid 0, result 0, flags 0, err 0, multiply counter and accumulators 0.
REQ-026 Reset during MUL SHALL abort the multiply with no output; first accept is legal on the first edge after rst_n rises.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN defined: opcodes E/F behave per REQ-013..021, err=0 for all ops.
REQ-028 ALU_PIPE_MUL_EN undefined: no multiplier logic or MUL state; E/F complete in 1 cycle with result 0, flags unchanged, err=1; all other ops err=0.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-029 ADD a=0x7F b=0x01 -> next cycle out_valid=1, result=0x80, flags C0 V1 Z0 N1.
REQ-030 ADD 0xFF+0x01 then ADC 0x00+0x00 back-to-back -> 0x00 (C1 Z1) then 0x01 (C0 Z0); SUB 0x10-0x10 -> 0x00, C1 Z1.
REQ-031 MUL 0x0F*0x11 -> in_ready low 8 cycles, result 0xFF, C0, out_valid 9 cycles after accept; MULH 0x10*0x10 -> 0x01, C1.
REQ-032 ADD result with out_ready low 3 cycles -> result/flags stable, in_ready low; pending in_valid accepted on the out_ready-high edge.
REQ-033 rst_n low 4 cycles into MUL -> out_valid 0, flags 0, state IDLE; next ADD 0x02+0x03 -> 0x05.
REQ-034 Build without ALU_PIPE_MUL_EN: op E -> 1-cycle result 0x00, err=1, flags unchanged from prior op.
